// File: rtl/aximm_window_ctrl.sv
// Window-change controller for an AXI-MM address window: gates new AW/AR while it drains outstanding bursts, then swaps window_addr.
// Optional drain timeout is enabled by defining AXIMM_WINDOW_CTRL_TIMEOUT_EN.
module aximm_window_ctrl #(
  parameter int AW      = 64,
  parameter int CW      = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] req_addr,
  input  logic          req_valid,
  output logic          req_ready,
  output logic          req_done,
  output logic          req_err,
  output logic [AW-1:0] window_addr,
  input  logic          s_awvalid,
  output logic          s_awready,
  output logic          m_awvalid,
  input  logic          m_awready,
  input  logic          s_arvalid,
  output logic          s_arready,
  output logic          m_arvalid,
  input  logic          m_arready,
  input  logic          b_fire,
  input  logic          r_last_fire,
  output logic          busy
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both high at the rising edge;
  // valid never depends on ready, and the requester holds req_addr stable while req_valid is high.

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] window_addr_q, window_addr_d;
  logic [AW-1:0] pending_q, pending_d;
  logic          req_done_q, req_done_d;
  logic          open_aw, open_ar;
  logic          aw_acc, ar_acc;

  // Saturating up/down count; increments never overflow because the gate closes at CNT_MAX.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                             input logic inc, input logic dec);
    logic [CW-1:0] r;
    r = c;
    if (inc && !dec) r = c + CW'(1);
    else if (dec && !inc && (c != '0)) r = c - CW'(1);
    return r;
  endfunction

  assign open_aw   = (state_q == IDLE) && (wr_cnt_q != CNT_MAX);
  assign open_ar   = (state_q == IDLE) && (rd_cnt_q != CNT_MAX);
  assign m_awvalid = s_awvalid & open_aw;
  assign s_awready = m_awready & open_aw;
  assign m_arvalid = s_arvalid & open_ar;
  assign s_arready = m_arready & open_ar;
  assign aw_acc    = m_awvalid & m_awready;
  assign ar_acc    = m_arvalid & m_arready;

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q == DRAIN);
  assign req_done    = req_done_q;
  assign window_addr = window_addr_q;

`ifdef AXIMM_WINDOW_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          req_err_q, req_err_d;
  assign req_err = req_err_q;
`else
  assign req_err = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = cnt_next(wr_cnt_q, aw_acc, b_fire);
    rd_cnt_d      = cnt_next(rd_cnt_q, ar_acc, r_last_fire);
    window_addr_d = window_addr_q;
    pending_d     = pending_q;
    req_done_d    = 1'b0;
`ifdef AXIMM_WINDOW_CTRL_TIMEOUT_EN
    timer_d       = '0;
    req_err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          pending_d = req_addr;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if ((wr_cnt_q == '0) && (rd_cnt_q == '0)) begin
          window_addr_d = pending_q;
          req_done_d    = 1'b1;
          state_d       = IDLE;
        end
`ifdef AXIMM_WINDOW_CTRL_TIMEOUT_EN
        else if (timer_q == TIMER_LAST) begin
          req_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      window_addr_q <= '0;
      pending_q     <= '0;
      req_done_q    <= 1'b0;
`ifdef AXIMM_WINDOW_CTRL_TIMEOUT_EN
      timer_q       <= '0;
      req_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      window_addr_q <= window_addr_d;
      pending_q     <= pending_d;
      req_done_q    <= req_done_d;
`ifdef AXIMM_WINDOW_CTRL_TIMEOUT_EN
      timer_q       <= timer_d;
      req_err_q     <= req_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_aximm_window_ctrl.sv
// Bench for aximm_window_ctrl: directed scenarios with literal checks plus a per-cycle reference model.
module tb_aximm_window_ctrl;

  localparam int CW      = 2;
  localparam int TMO     = 16;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef AXIMM_WINDOW_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [63:0] A1 = 64'h0000_0010_0000_0000;
  localparam logic [63:0] A2 = 64'h0000_00AB_CDEF_0000;
  localparam logic [63:0] A3 = 64'h1234_5678_0000_1000;
  localparam logic [63:0] A4 = 64'h0000_0000_8000_0000;
  localparam logic [63:0] A5 = 64'hDEAD_BEEF_0000_0000;
  localparam logic [63:0] A6 = 64'h0000_0F00_0000_0000;
  localparam logic [63:0] A7 = 64'h5555_0000_AAAA_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] req_addr;
  logic        req_valid, req_ready, req_done, req_err;
  logic [63:0] window_addr;
  logic        s_awvalid, s_awready, m_awvalid, m_awready;
  logic        s_arvalid, s_arready, m_arvalid, m_arready;
  logic        b_fire, r_last_fire, busy;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  aximm_window_ctrl #(.AW(64), .CW(CW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
    .req_done(req_done), .req_err(req_err), .window_addr(window_addr),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .b_fire(b_fire), .r_last_fire(r_last_fire), .busy(busy)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge, literal checks happen on the falling edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    s_awvalid = 0; m_awready = 0; s_arvalid = 0; m_arready = 0;
    b_fire = 0; r_last_fire = 0;
  endtask

  // reference model: transaction counts as integers, window swap as an event
  int          m_wr, m_rd, m_timer;
  bit          m_drain, m_done, m_err, m_valid;
  logic [63:0] m_win, m_pend;

  initial m_valid = 1'b0;

  always @(negedge clk) begin
    logic open_aw, open_ar;
    int   new_wr, new_rd;
    open_aw = !m_drain && (m_wr < CNT_MAX);
    open_ar = !m_drain && (m_rd < CNT_MAX);
    if (m_valid) begin
      chk1("m_awvalid", m_awvalid, s_awvalid && open_aw);
      chk1("s_awready", s_awready, m_awready && open_aw);
      chk1("m_arvalid", m_arvalid, s_arvalid && open_ar);
      chk1("s_arready", s_arready, m_arready && open_ar);
      chk1("req_ready", req_ready, !m_drain);
      chk1("busy", busy, m_drain);
      chk1("req_done", req_done, m_done);
      chk1("req_err", req_err, m_err);
      chk64("window_addr", window_addr, m_win);
    end
    if (reset) begin
      m_wr = 0; m_rd = 0; m_timer = 0; m_drain = 0;
      m_done = 0; m_err = 0; m_win = '0; m_pend = '0; m_valid = 1'b1;
    end else if (m_valid) begin
      new_wr = m_wr + ((s_awvalid && m_awready && open_aw) ? 1 : 0) - (b_fire ? 1 : 0);
      new_rd = m_rd + ((s_arvalid && m_arready && open_ar) ? 1 : 0) - (r_last_fire ? 1 : 0);
      if (new_wr < 0) new_wr = 0;
      if (new_rd < 0) new_rd = 0;
      m_done = 0;
      m_err  = 0;
      if (!m_drain) begin
        if (req_valid) begin
          m_drain = 1; m_pend = req_addr; m_timer = 0;
        end
      end else if (m_wr == 0 && m_rd == 0) begin
        m_win = m_pend; m_done = 1; m_drain = 0;
      end else if (TO_EN && m_timer == TMO - 1) begin
        m_err = 1; m_drain = 0;
      end else begin
        m_timer++;
      end
      m_wr = new_wr;
      m_rd = new_rd;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; req_valid = 0; req_addr = '0;
    clear_bus();
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // reset state: open gates follow the slave side
    s_awvalid = 1; s_arvalid = 1;
    @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk64("rst_window", window_addr, 64'h0);
    chk1("rst_done", req_done, 1'b0);
    chk1("rst_err", req_err, 1'b0);
    chk1("rst_m_awvalid", m_awvalid, 1'b1);
    chk1("rst_m_arvalid", m_arvalid, 1'b1);
    cyc();
    clear_bus();

    // idle bus: done two cycles after the handshake
    req_valid = 1; req_addr = A1;
    cyc();
    req_valid = 0;
    @(negedge clk);
    chk1("idle_busy_n1", busy, 1'b1);
    chk1("idle_ready_n1", req_ready, 1'b0);
    chk1("idle_done_n1", req_done, 1'b0);
    cyc();
    @(negedge clk);
    chk1("idle_done_n2", req_done, 1'b1);
    chk64("idle_window_n2", window_addr, A1);
    cyc();
    @(negedge clk);
    chk1("idle_done_n3", req_done, 1'b0);
    cyc();

    // 3 AW + 2 AR outstanding, then a window change
    s_awvalid = 1; m_awready = 1;
    repeat (3) begin
      @(negedge clk);
      chk1("out_aw_open", s_awready, 1'b1);
      cyc();
    end
    clear_bus();
    s_arvalid = 1; m_arready = 1;
    repeat (2) cyc();
    clear_bus();
    req_valid = 1; req_addr = A2;
    cyc();
    req_valid = 0;
    s_awvalid = 1; m_awready = 1; s_arvalid = 1; m_arready = 1;
    @(negedge clk);
    chk1("drain_m_awvalid", m_awvalid, 1'b0);
    chk1("drain_s_awready", s_awready, 1'b0);
    chk1("drain_m_arvalid", m_arvalid, 1'b0);
    chk1("drain_s_arready", s_arready, 1'b0);
    cyc();
    b_fire = 1;
    cyc();
    cyc();
    r_last_fire = 1;
    cyc();
    b_fire = 0;
    @(negedge clk);
    chk1("out_last_busy", busy, 1'b1);
    chk1("out_last_done", req_done, 1'b0);
    cyc();
    clear_bus();
    @(negedge clk);
    chk1("out_zero_done", req_done, 1'b0);
    cyc();
    @(negedge clk);
    chk1("out_done", req_done, 1'b1);
    chk64("out_window", window_addr, A2);
    cyc();

    // simultaneous AW accept and B with one outstanding
    s_awvalid = 1; m_awready = 1;
    cyc();
    b_fire = 1;
    @(negedge clk);
    chk1("same_aw_open", s_awready, 1'b1);
    cyc();
    clear_bus();
    req_valid = 1; req_addr = A3;
    cyc();
    req_valid = 0;
    repeat (4) begin
      @(negedge clk);
      chk1("same_busy", busy, 1'b1);
      chk1("same_no_done", req_done, 1'b0);
      cyc();
    end
    b_fire = 1;
    cyc();
    b_fire = 0;
    @(negedge clk);
    chk1("same_done_m1", req_done, 1'b0);
    cyc();
    @(negedge clk);
    chk1("same_done_m2", req_done, 1'b1);
    chk64("same_window", window_addr, A3);
    cyc();

    // responses while counters are zero must not wrap them
    b_fire = 1; r_last_fire = 1;
    repeat (2) cyc();
    clear_bus();
    s_arvalid = 1; m_arready = 1;
    cyc();
    clear_bus();
    req_valid = 1; req_addr = A4;
    cyc();
    req_valid = 0;
    cyc();
    @(negedge clk);
    chk1("clamp_wait", req_done, 1'b0);
    chk1("clamp_busy", busy, 1'b1);
    r_last_fire = 1;
    cyc();
    r_last_fire = 0;
    cyc();
    @(negedge clk);
    chk1("clamp_done", req_done, 1'b1);
    chk64("clamp_window", window_addr, A4);
    cyc();

    // full read counter blocks AR until a response frees a slot
    s_arvalid = 1; m_arready = 1;
    repeat (3) cyc();
    repeat (2) begin
      @(negedge clk);
      chk1("full_s_arready", s_arready, 1'b0);
      chk1("full_m_arvalid", m_arvalid, 1'b0);
      cyc();
    end
    r_last_fire = 1;
    @(negedge clk);
    chk1("full_resp_cycle", s_arready, 1'b0);
    cyc();
    r_last_fire = 0;
    @(negedge clk);
    chk1("full_reopen_ready", s_arready, 1'b1);
    chk1("full_reopen_valid", m_arvalid, 1'b1);
    cyc();
    clear_bus();
    r_last_fire = 1;
    repeat (3) cyc();
    clear_bus();
    cyc();

    // reset during drain aborts the request
    s_awvalid = 1; m_awready = 1;
    cyc();
    clear_bus();
    req_valid = 1; req_addr = A5;
    cyc();
    req_valid = 0;
    @(negedge clk);
    chk1("rstd_busy", busy, 1'b1);
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    req_valid = 1; req_addr = A6;
    @(negedge clk);
    chk1("rstd_idle", busy, 1'b0);
    chk1("rstd_ready", req_ready, 1'b1);
    chk64("rstd_window", window_addr, 64'h0);
    chk1("rstd_no_done", req_done, 1'b0);
    cyc();
    req_valid = 0;
    cyc();
    @(negedge clk);
    chk1("rstd_new_done", req_done, 1'b1);
    chk64("rstd_new_window", window_addr, A6);
    cyc();

    // a B that never returns
    s_awvalid = 1; m_awready = 1;
    cyc();
    clear_bus();
    req_valid = 1; req_addr = A7;
    cyc();
    req_valid = 0;
    if (TO_EN) begin
      repeat (TMO) begin
        @(negedge clk);
        chk1("tmo_busy", busy, 1'b1);
        chk1("tmo_no_err", req_err, 1'b0);
        cyc();
      end
      @(negedge clk);
      chk1("tmo_err", req_err, 1'b1);
      chk1("tmo_ready", req_ready, 1'b1);
      chk1("tmo_no_done", req_done, 1'b0);
      chk64("tmo_window", window_addr, A6);
      cyc();
      @(negedge clk);
      chk1("tmo_err_pulse", req_err, 1'b0);
      b_fire = 1;
      cyc();
      b_fire = 0;
      cyc();
    end else begin
      repeat (40) begin
        @(negedge clk);
        chk1("wait_busy", busy, 1'b1);
        chk1("wait_no_err", req_err, 1'b0);
        cyc();
      end
      b_fire = 1;
      cyc();
      b_fire = 0;
      cyc();
      @(negedge clk);
      chk1("wait_done", req_done, 1'b1);
      chk64("wait_window", window_addr, A7);
      cyc();
    end

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
